// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flip-flop.
// It takes one operand bit per clock, LSB first, and needs WIDTH RUN cycles
// per operation.
//
// Parameters:
//   WIDTH  operand and sum width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   start  latch a/b and begin; accepted in IDLE or DONE, ignored in RUN
//   sub    (only with SERIAL_ADDER_SUB_EN) subtract a-b instead of add
//   a, b   operands, sampled only on an accepted start
//   busy   high while the adder is running
//   done   one-cycle pulse when sum/carry are valid
//   sum    result; the LSB-first bits shift in from the top
//   carry  carry-out of the MSB (with sub: 1 means no borrow)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' input.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full adder built from two half adders.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_cout;

    assign ha0_s   = a_q[0] ^ b_q[0];
    assign ha0_c   = a_q[0] & b_q[0];
    assign ha1_s   = ha0_s ^ c_q;
    assign ha1_c   = ha0_s & c_q;
    assign fa_cout = ha0_c | ha1_c;

    assign accept = start && (state_q != StRun);

`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1: invert B at latch and seed the carry with 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub;
`else
    assign b_load = b;
    assign c_load = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b_load;
                    c_d     = c_load;
                    sum_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {ha1_s, sum_q[WIDTH-1:1]};
                c_d   = fa_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    // carry output only moves on the final bit
                    carry_d = fa_cout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 instance for directed and random ops,
// WIDTH=2 instance for an exhaustive sweep. Expected results come from
// plain integer arithmetic on the operands.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
    logic         sub2 = 1'b0;
`endif

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       busy2, done2, carry2;
    logic [1:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub2),
`endif
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .carry (carry2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {carry,sum} is a+b, or for subtraction (a-b mod 2^W, no-borrow flag).
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sv);
        int unsigned r;
        if (sv) begin
            r = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
            return {(av >= bv), r[W-1:0]};
        end
        r = int'(av) + int'(bv);
        return r[W:0];
    endfunction

    // Wait for done after the accept edge; returns edges elapsed.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv);
        logic [W:0]   exp;
        logic [W:0]   res;
        int           cyc;
        exp = model(av, bv, sv);
        @(negedge clk);
        a = av;
        b = bv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sv;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(W));
        res = {carry, sum};
        check({tag, "_res"}, 32'(res), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, "_hold"}, 32'({carry, sum}), 32'(exp));
    endtask

    initial begin
        int         cyc;
        logic       seen;
        logic [W-1:0] ra, rb;
        logic       rs;

        // Reset state
        #12;
        check("rst_out", 32'({busy, done, carry, sum}), 32'd0);
        check("rst_out2", 32'({busy2, done2, carry2, sum2}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("h35_12", 8'h35, 8'h12, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("h35_idle_hold", 32'({carry, sum}), 32'h047);
        do_op("hff_01", 8'hFF, 8'h01, 1'b0);
        do_op("h00_00", 8'h00, 8'h00, 1'b0);
        do_op("hff_01b", 8'hFF, 8'h01, 1'b0);

        // Reset mid-RUN aborts with no done afterwards
        @(negedge clk);
        a = 8'h35;
        b = 8'h12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrun_rst", 32'({busy, done, carry, sum}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            seen |= done | busy;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);

        // Back-to-back with start held high; operands changed during RUN are ignored
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h01;
        wait_done(cyc);
        check("b2b_lat1", 32'(cyc), 32'(W));
        check("b2b_res1", 32'({carry, sum}), 32'h100);
        wait_done(cyc);
        start = 1'b0;
        check("b2b_period", 32'(cyc), 32'(W + 1));
        check("b2b_res2", 32'({carry, sum}), 32'h002);
        repeat (2) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_10_20", 8'h10, 8'h20, 1'b1);
        do_op("sub_20_10", 8'h20, 8'h10, 1'b1);
`endif

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op("rand", ra, rb, rs);
        end

        // WIDTH=2 exhaustive sweep
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                a2 = 2'(i);
                b2 = 2'(j);
                start2 = 1'b1;
                @(posedge clk);
                #1;
                start2 = 1'b0;
                cyc = 0;
                do begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end while (!done2 && cyc < 10);
                check("w2_lat", 32'(cyc), 32'd2);
                check("w2_res", 32'({carry2, sum2}), 32'(i + j));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
